// File: rtl/lc3_mmio_bus_if.sv
// LC-3 MAR/MDR access handshake between the CPU (master) and a memory-mapped target (slave).
interface lc3_mmio_bus_if;
   logic        i_MIO_EN;   // access request, held until R is seen
   logic        i_R_W;      // 1=write, 0=read
   logic [15:0] i_Addr;     // MAR
   logic [15:0] i_Data;     // MDR write data
   logic        o_Hit;      // target decodes i_Addr
   logic [15:0] o_Data;     // read data, valid while o_Ready
   logic        o_Ready;    // R bit

   modport master (output i_MIO_EN, i_R_W, i_Addr, i_Data,
                   input  o_Hit, o_Data, o_Ready);
   modport slave  (input  i_MIO_EN, i_R_W, i_Addr, i_Data,
                   output o_Hit, o_Data, o_Ready);
endinterface

// File: rtl/lc3_mmio_responder.sv
// LC-3 keyboard/display device registers (KBSR/KBDR/DSR/DDR) behind the MAR/MDR handshake.
// An accepted access completes LATENCY edges later (accept edge included); the register side
// effect commits on the READY-entry edge and the read value is captured on that same edge.
module lc3_mmio_responder #(
   parameter logic [15:0] BASE_ADDR = 16'hFE00,
   parameter int unsigned LATENCY   = 2
) (
   input  logic                 i_CLK,
   input  logic                 i_Reset,
   lc3_mmio_bus_if.slave        bus,
   input  logic                 i_Key_Valid,
   input  logic [7:0]           i_Key_Data,
   output logic                 o_Disp_Valid,
   output logic [7:0]           o_Disp_Data,
   input  logic                 i_Disp_Ack,
   output logic                 o_KB_Int,
   output logic                 o_Disp_Int
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   localparam logic [1:0] SEL_KBSR = 2'd0;
   localparam logic [1:0] SEL_KBDR = 2'd1;
   localparam logic [1:0] SEL_DSR  = 2'd2;
   localparam logic [1:0] SEL_DDR  = 2'd3;

   // cnt holds the number of edges still to go before READY, counted from the WAIT state
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [1:0]  lat_sel;
   logic        lat_rw;
   logic        lat_ie;
   logic [7:0]  lat_chr;
   logic [15:0] rdata_q;

   logic        kb_rdy, kb_ie, kb_ovr;
   logic [7:0]  kbdr;
   logic        ds_rdy, ds_ie;
   logic [7:0]  ddr;
   logic        disp_valid;

   logic [15:0] offs;
   logic        hit;
   logic [1:0]  sel_now;
   logic        accept, commit;
   logic [1:0]  c_sel;
   logic        c_rw, c_ie;
   logic [7:0]  c_chr;
   logic        cm_kbdr_rd, cm_kbsr_wr, cm_dsr_wr, cm_ddr_wr;
   logic [15:0] rd_val;
   logic        unused_data;

   // Device window is four even addresses starting at BASE_ADDR
   assign offs    = bus.i_Addr - BASE_ADDR;
   assign hit     = (offs[15:3] == 13'd0) && !offs[0];
   assign sel_now = offs[2:1];

   assign accept = (state == ST_IDLE) && bus.i_MIO_EN && hit;
   assign commit = (accept && (LATENCY == 1)) || ((state == ST_WAIT) && (cnt == 4'd1));

   // With LATENCY=1 the commit edge is the accept edge, so take the live bus fields then
   assign c_sel = (state == ST_IDLE) ? sel_now            : lat_sel;
   assign c_rw  = (state == ST_IDLE) ? bus.i_R_W          : lat_rw;
   assign c_ie  = (state == ST_IDLE) ? bus.i_Data[14]     : lat_ie;
   assign c_chr = (state == ST_IDLE) ? bus.i_Data[7:0]    : lat_chr;

   assign cm_kbdr_rd = commit && !c_rw && (c_sel == SEL_KBDR);
   assign cm_kbsr_wr = commit &&  c_rw && (c_sel == SEL_KBSR);
   assign cm_dsr_wr  = commit &&  c_rw && (c_sel == SEL_DSR);
   assign cm_ddr_wr  = commit &&  c_rw && (c_sel == SEL_DDR);

   // Only IE and the character byte of the write data matter to any register
   assign unused_data = ^{bus.i_Data[15], bus.i_Data[13:8]};

   // Register read mux for the access being committed; unused bits read 0
   always_comb begin
      rd_val = 16'h0000;
      case (c_sel)
         SEL_KBSR: rd_val = {kb_rdy, kb_ie, kb_ovr, 13'd0};
         SEL_KBDR: rd_val = {8'h00, kbdr};
         SEL_DSR:  rd_val = {ds_rdy, ds_ie, 14'd0};
         default:  rd_val = {8'h00, ddr};
      endcase
   end

   // Bus FSM: IDLE -> WAIT -> READY, captures read data on READY entry
   always_ff @(posedge i_CLK or posedge i_Reset) begin
      if (i_Reset) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         lat_sel <= 2'd0;
         lat_rw  <= 1'b0;
         lat_ie  <= 1'b0;
         lat_chr <= 8'h00;
         rdata_q <= 16'h0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_sel <= sel_now;
                  lat_rw  <= bus.i_R_W;
                  lat_ie  <= bus.i_Data[14];
                  lat_chr <= bus.i_Data[7:0];
                  if (LATENCY == 1) begin
                     state   <= ST_READY;
                     rdata_q <= rd_val;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd1) begin
                  state   <= ST_READY;
                  rdata_q <= rd_val;
               end
               cnt <= cnt - 4'd1;
            end
            ST_READY: begin
               if (!bus.i_MIO_EN) begin
                  state   <= ST_IDLE;
                  rdata_q <= 16'h0000;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Keyboard: load char when empty, flag overrun when full; a KBDR read on the same edge frees the slot
   always_ff @(posedge i_CLK or posedge i_Reset) begin
      if (i_Reset) begin
         kb_rdy <= 1'b0;
         kb_ie  <= 1'b0;
         kb_ovr <= 1'b0;
         kbdr   <= 8'h00;
      end else begin
         if (cm_kbsr_wr)
            kb_ie <= c_ie;
         if (i_Key_Valid) begin
            if (cm_kbdr_rd || !kb_rdy) begin
               kbdr   <= i_Key_Data;
               kb_rdy <= 1'b1;
               if (cm_kbdr_rd)
                  kb_ovr <= 1'b0;
            end else begin
               kb_ovr <= 1'b1;
            end
         end else if (cm_kbdr_rd) begin
            kb_rdy <= 1'b0;
            kb_ovr <= 1'b0;
         end
      end
   end

   // Display: DDR write hands a char to the display when ready; ack returns the ready bit
   always_ff @(posedge i_CLK or posedge i_Reset) begin
      if (i_Reset) begin
         ds_rdy     <= 1'b1;
         ds_ie      <= 1'b0;
         ddr        <= 8'h00;
         disp_valid <= 1'b0;
      end else begin
         if (cm_dsr_wr)
            ds_ie <= c_ie;
         // disp_valid=1 implies ds_rdy=0, so a write and an ack never both take effect
         if (cm_ddr_wr && ds_rdy) begin
            ddr        <= c_chr;
            ds_rdy     <= 1'b0;
            disp_valid <= 1'b1;
         end else if (disp_valid && i_Disp_Ack) begin
            disp_valid <= 1'b0;
            ds_rdy     <= 1'b1;
         end
      end
   end

   assign bus.o_Hit   = hit;
   assign bus.o_Ready = (state == ST_READY);
   assign bus.o_Data  = rdata_q;

   assign o_Disp_Valid = disp_valid;
   assign o_Disp_Data  = ddr;
   assign o_KB_Int     = kb_rdy & kb_ie;
   assign o_Disp_Int   = ds_rdy & ds_ie;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// Bench for lc3_mmio_responder: directed scenarios plus a randomized run against a register-level model.
module tb_lc3_mmio_responder;
   localparam int LAT = 2;
   localparam logic [15:0] A_KBSR = 16'hFE00;
   localparam logic [15:0] A_KBDR = 16'hFE02;
   localparam logic [15:0] A_DSR  = 16'hFE04;
   localparam logic [15:0] A_DDR  = 16'hFE06;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_v;
   logic [7:0] key_d;
   logic       disp_v;
   logic [7:0] disp_d;
   logic       ack;
   logic       kb_int, ds_int;

   int n_tests = 0;
   int n_fail  = 0;

   // model state, named after the architectural register bits
   bit       m_kb_rdy, m_kb_ie, m_kb_ovr;
   bit [7:0] m_kb_chr;
   bit       m_ds_rdy, m_ds_ie, m_dv;
   bit [7:0] m_ddr;

   always #5 clk = ~clk;

   lc3_mmio_bus_if bus();

   lc3_mmio_responder #(.BASE_ADDR(16'hFE00), .LATENCY(LAT)) dut (
      .i_CLK(clk), .i_Reset(rst), .bus(bus),
      .i_Key_Valid(key_v), .i_Key_Data(key_d),
      .o_Disp_Valid(disp_v), .o_Disp_Data(disp_d), .i_Disp_Ack(ack),
      .o_KB_Int(kb_int), .o_Disp_Int(ds_int));

   // ---------------- reference model ----------------
   task automatic m_reset();
      m_kb_rdy = 0; m_kb_ie = 0; m_kb_ovr = 0; m_kb_chr = 0;
      m_ds_rdy = 1; m_ds_ie = 0; m_dv = 0; m_ddr = 0;
   endtask

   function automatic logic [15:0] m_read(input logic [15:0] a);
      if (a == A_KBSR) return {m_kb_rdy, m_kb_ie, m_kb_ovr, 13'd0};
      if (a == A_KBDR) return {8'h00, m_kb_chr};
      if (a == A_DSR)  return {m_ds_rdy, m_ds_ie, 14'd0};
      return {8'h00, m_ddr};
   endfunction

   task automatic m_access(input logic rw, input logic [15:0] a, input logic [15:0] d);
      if (!rw) begin
         if (a == A_KBDR) begin m_kb_rdy = 0; m_kb_ovr = 0; end
      end else if (a == A_KBSR) m_kb_ie = d[14];
      else if (a == A_DSR) m_ds_ie = d[14];
      else if (a == A_DDR && m_ds_rdy) begin m_ddr = d[7:0]; m_ds_rdy = 0; m_dv = 1; end
   endtask

   // ---------------- stimulus helpers ----------------
   // Runs one access; lat = edges from accept (inclusive) to o_Ready, -1 on timeout
   task automatic bus_acc(input logic rw, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
      bus.i_R_W = rw; bus.i_Addr = a; bus.i_Data = d; bus.i_MIO_EN = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!bus.o_Ready && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!bus.o_Ready) lat = -1;
      rd = bus.o_Data;
      bus.i_MIO_EN = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic key(input logic [7:0] c);
      key_v = 1'b1; key_d = c;
      @(posedge clk); #1;
      key_v = 1'b0;
      if (!m_kb_rdy) begin m_kb_chr = c; m_kb_rdy = 1; end
      else m_kb_ovr = 1;
   endtask

   task automatic disp_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      if (m_dv) begin m_dv = 0; m_ds_rdy = 1; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [15:0] rd; int lat;
      rst = 1'b1; #12;
      n_tests++; if (bus.o_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus.o_Ready); end
      n_tests++; if (bus.o_Data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", bus.o_Data); end
      n_tests++; if (disp_v !== 1'b0) begin n_fail++; $display("FAIL rst_disp_valid got %b want 0", disp_v); end
      @(posedge clk); #1; rst = 1'b0; m_reset();
      bus_acc(1'b0, A_DSR, 16'h0, rd, lat);
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL dsr_latency got %0d want %0d", lat, LAT); end
      n_tests++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL rst_dsr got %h want 8000", rd); end
      n_tests++; if (bus.o_Data !== 16'h0000 || bus.o_Ready !== 1'b0) begin n_fail++; $display("FAIL idle_after_access got data=%h rdy=%b want 0000/0", bus.o_Data, bus.o_Ready); end
      bus_acc(1'b0, A_KBSR, 16'h0, rd, lat);
      n_tests++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL rst_kbsr got %h want 0000", rd); end
   endtask

   task automatic test_keyboard();
      logic [15:0] rd, exp; int lat;
      key(8'h41);
      exp = m_read(A_KBSR); m_access(1'b0, A_KBSR, 0); bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL kbsr_after_key got %h want %h", rd, exp); end
      exp = m_read(A_KBDR); m_access(1'b0, A_KBDR, 0); bus_acc(1'b0, A_KBDR, 0, rd, lat);
      n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL kbdr_read got %h want %h", rd, exp); end
      exp = m_read(A_KBSR); m_access(1'b0, A_KBSR, 0); bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL kbsr_cleared got %h want %h", rd, exp); end
   endtask

   task automatic test_overrun();
      logic [15:0] rd; int lat;
      key(8'h41); key(8'h42);
      m_access(1'b0, A_KBSR, 0); bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== 16'hA000) begin n_fail++; $display("FAIL overrun_kbsr got %h want A000", rd); end
      m_access(1'b0, A_KBDR, 0); bus_acc(1'b0, A_KBDR, 0, rd, lat);
      n_tests++; if (rd !== 16'h0041) begin n_fail++; $display("FAIL overrun_kbdr got %h want 0041", rd); end
      bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL overrun_cleared got %h want 0000", rd); end
   endtask

   // Key strobe landing on the KBDR read commit edge
   task automatic test_key_collide();
      logic [15:0] rd; int lat;
      key(8'h43);
      bus.i_R_W = 1'b0; bus.i_Addr = A_KBDR; bus.i_MIO_EN = 1'b1;
      @(posedge clk); #1;                       // accept
      key_v = 1'b1; key_d = 8'h44;
      @(posedge clk); #1;                       // commit (LAT=2)
      key_v = 1'b0;
      n_tests++; if (bus.o_Ready !== 1'b1 || bus.o_Data !== 16'h0043) begin n_fail++; $display("FAIL collide_read got rdy=%b data=%h want 1/0043", bus.o_Ready, bus.o_Data); end
      bus.i_MIO_EN = 1'b0; @(posedge clk); #1;
      m_kb_chr = 8'h44; m_kb_rdy = 1; m_kb_ovr = 0;
      bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL collide_kbsr got %h want 8000", rd); end
      m_access(1'b0, A_KBDR, 0); bus_acc(1'b0, A_KBDR, 0, rd, lat);
      n_tests++; if (rd !== 16'h0044) begin n_fail++; $display("FAIL collide_kbdr got %h want 0044", rd); end
   endtask

   task automatic test_display();
      logic [15:0] rd; int lat;
      m_access(1'b1, A_DDR, 16'h0048); bus_acc(1'b1, A_DDR, 16'h0048, rd, lat);
      n_tests++; if (disp_v !== 1'b1 || disp_d !== 8'h48) begin n_fail++; $display("FAIL ddr_write got v=%b d=%h want 1/48", disp_v, disp_d); end
      bus_acc(1'b0, A_DSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL dsr_busy got %h want 0000", rd); end
      m_access(1'b1, A_DDR, 16'h0049); bus_acc(1'b1, A_DDR, 16'h0049, rd, lat);
      n_tests++; if (lat !== LAT || disp_d !== 8'h48) begin n_fail++; $display("FAIL ddr_drop got lat=%0d d=%h want %0d/48", lat, disp_d, LAT); end
      disp_ack();
      n_tests++; if (disp_v !== 1'b0) begin n_fail++; $display("FAIL disp_ack got v=%b want 0", disp_v); end
      bus_acc(1'b0, A_DSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL dsr_after_ack got %h want 8000", rd); end
      disp_ack();                                // stray ack is ignored
      n_tests++; if (disp_v !== 1'b0) begin n_fail++; $display("FAIL stray_ack got v=%b want 0", disp_v); end
   endtask

   task automatic test_int();
      logic [15:0] rd; int lat;
      m_access(1'b1, A_KBSR, 16'hFFFF); bus_acc(1'b1, A_KBSR, 16'hFFFF, rd, lat);
      bus_acc(1'b0, A_KBSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h4000) begin n_fail++; $display("FAIL kbsr_ie got %h want 4000", rd); end
      n_tests++; if (kb_int !== 1'b0) begin n_fail++; $display("FAIL kbint_idle got %b want 0", kb_int); end
      key(8'h55);
      n_tests++; if (kb_int !== 1'b1) begin n_fail++; $display("FAIL kbint_set got %b want 1", kb_int); end
      m_access(1'b0, A_KBDR, 0); bus_acc(1'b0, A_KBDR, 0, rd, lat);
      n_tests++; if (kb_int !== 1'b0) begin n_fail++; $display("FAIL kbint_clear got %b want 0", kb_int); end
      m_access(1'b1, A_DSR, 16'h4000); bus_acc(1'b1, A_DSR, 16'h4000, rd, lat);
      n_tests++; if (ds_int !== 1'b1) begin n_fail++; $display("FAIL dsint_set got %b want 1", ds_int); end
   endtask

   task automatic test_abort();
      logic [15:0] rd; int lat;
      bus.i_R_W = 1'b1; bus.i_Addr = A_DDR; bus.i_Data = 16'h005A; bus.i_MIO_EN = 1'b1;
      @(posedge clk); #1;                       // accepted, now waiting
      rst = 1'b1; #1;
      n_tests++; if (bus.o_Ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b want 0", bus.o_Ready); end
      @(posedge clk); #1;
      bus.i_MIO_EN = 1'b0; rst = 1'b0; m_reset();
      n_tests++; if (disp_v !== 1'b0) begin n_fail++; $display("FAIL abort_disp got v=%b want 0", disp_v); end
      bus_acc(1'b0, A_DSR, 0, rd, lat);
      n_tests++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL abort_dsr got %h want 8000", rd); end
      // reset while READY drops R without waiting for an edge
      bus.i_R_W = 1'b0; bus.i_Addr = A_DSR; bus.i_MIO_EN = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      rst = 1'b1; #1;
      n_tests++; if (bus.o_Ready !== 1'b0 || bus.o_Data !== 16'h0000) begin n_fail++; $display("FAIL ready_abort got rdy=%b data=%h want 0/0000", bus.o_Ready, bus.o_Data); end
      @(posedge clk); #1;
      bus.i_MIO_EN = 1'b0; rst = 1'b0; m_reset();
      // non-hit access is ignored
      begin
         int seen = 0;
         bus.i_R_W = 1'b0; bus.i_Addr = 16'h3000; bus.i_MIO_EN = 1'b1; #1;
         n_tests++; if (bus.o_Hit !== 1'b0) begin n_fail++; $display("FAIL nohit_hit got %b want 0", bus.o_Hit); end
         repeat (8) begin @(posedge clk); #1; if (bus.o_Ready) seen++; end
         bus.i_MIO_EN = 1'b0; @(posedge clk); #1;
         n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL nohit_ready got %0d ready cycles want 0", seen); end
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, exp, a, d; int lat; int op; logic rw;
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 5);
         if (op == 0) key(8'($urandom));
         else if (op == 1) disp_ack();
         else if (op == 5) begin
            a = 16'($urandom_range(0, 16'hFDFF));
            bus.i_Addr = a; #1;
            n_tests++; if (bus.o_Hit !== 1'b0) begin n_fail++; $display("FAIL rnd_nohit addr=%h got %b want 0", a, bus.o_Hit); end
         end else begin
            a  = 16'hFE00 + 16'($urandom_range(0, 3) * 2);
            d  = 16'($urandom);
            rw = (op == 4);
            exp = m_read(a);
            m_access(rw, a, d);
            bus.i_Addr = a; #1;
            n_tests++; if (bus.o_Hit !== 1'b1) begin n_fail++; $display("FAIL rnd_hit addr=%h got %b want 1", a, bus.o_Hit); end
            bus_acc(rw, a, d, rd, lat);
            n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd_lat i=%0d got %0d want %0d", i, lat, LAT); end
            if (!rw) begin
               n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL rnd_read i=%0d addr=%h got %h want %h", i, a, rd, exp); end
            end
         end
         n_tests++; if (disp_v !== m_dv || kb_int !== (m_kb_rdy & m_kb_ie) || ds_int !== (m_ds_rdy & m_ds_ie)) begin
            n_fail++; $display("FAIL rnd_status i=%0d got v=%b kbi=%b dsi=%b want %b/%b/%b", i, disp_v, kb_int, ds_int, m_dv, m_kb_rdy & m_kb_ie, m_ds_rdy & m_ds_ie);
         end
         if (m_dv) begin
            n_tests++; if (disp_d !== m_ddr) begin n_fail++; $display("FAIL rnd_disp_data i=%0d got %h want %h", i, disp_d, m_ddr); end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; key_v = 1'b0; key_d = 8'h00; ack = 1'b0;
      bus.i_MIO_EN = 1'b0; bus.i_R_W = 1'b0; bus.i_Addr = 16'h0000; bus.i_Data = 16'h0000;
      test_reset();
      test_keyboard();
      test_overrun();
      test_key_collide();
      test_display();
      do_reset();
      test_int();
      do_reset();
      test_abort();
      do_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
